parity_sched: RTL and testbench
===============================

PARITY_SCHED -- requirements
Module: parity_sched

Interface
REQ-001 Parameter FRAME_LEN, default 8: number of bits per frame, legal range 2..255.
REQ-002 Parameter CNT_W, default 8: bit-counter width; must satisfy 2**CNT_W > FRAME_LEN.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  2  per-requester frame request; bit i belongs to requester i.
REQ-006 gnt  output  2  one-hot grant; all zeros when nothing is granted.
REQ-007 in_valid  input  2  per-requester data-bit valid.
REQ-008 in_bit  input  2  per-requester serial data bit.
REQ-009 res_valid  output  1  parity result available.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_parity  output  1  XOR of all FRAME_LEN bits of the frame.
REQ-012 res_id  output  1  index of the requester that owned the frame.

Function
REQ-013 FSM states shall be IDLE, ACCUM and RESULT.
REQ-014 IDLE: gnt=00; if req!=00, the block shall select a winner, clear the accumulator and bit counter, load gnt with the winner, and enter ACCUM on the next edge.
REQ-015 Arbitration shall be round-robin: with both req bits set, the winner is the requester not served last; with one req bit set, that requester wins.
REQ-016 The priority pointer shall update when a frame completes or aborts, so the other requester has priority next.
REQ-017 ACCUM: on each cycle where in_valid[g]=1 for the granted index g, the block shall XOR in_bit[g] into the accumulator and increment the counter; in_valid/in_bit of the non-granted requester shall be ignored.
REQ-018 A cycle with in_valid[g]=0 shall be a stall: accumulator and counter hold.
REQ-019 On the cycle the FRAME_LEN-th valid bit is accepted, the block shall latch res_parity = accumulator ^ in_bit[g] and res_id = g, clear gnt, and enter RESULT. res_valid therefore rises one cycle after the last bit.
REQ-020 RESULT: res_valid=1; res_parity and res_id shall hold stable until res_ready=1, then return to IDLE on that edge.
REQ-021 Abort: if req[g] deasserts in ACCUM, including on the cycle the last bit arrives, the frame shall be discarded and the FSM returns to IDLE. No result is produced, gnt is cleared, and the pointer advances.
REQ-022 req changes during RESULT shall not affect the held result.
REQ-023 At least one IDLE cycle shall separate consecutive frames; a new grant is never issued while res_valid=1.
REQ-024 gnt shall be non-zero only in ACCUM and never have both bits set.
REQ-025 The counter shall not wrap; it is compared against FRAME_LEN-1 before incrementing.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, gnt=00, res_valid=0, res_parity=0, res_id=0, accumulator=0, counter=0, and the priority pointer favours requester 0.
REQ-027 rst asserted mid-frame or during RESULT shall discard the frame or result with no output pulse.
REQ-028 rst shall take precedence over all other inputs in the same cycle.

Structure
REQ-029 A shared package parity_sched_pkg shall hold the state enum type (IDLE, ACCUM, RESULT) and the requester-count constant (2).
REQ-030 The running parity shall be a sub-module parity_acc: a clear/enable XOR flop with inputs clk, rst, clr, en, d and output q, where q is updated to q^d when en=1.
REQ-031 Arbiter and FSM logic shall reside in parity_sched.

Verification
REQ-032 Single frame: req=01, requester 0 sends 1,0,1,1,0,0,1,0 with no stalls -> gnt=01 for 8 cycles, then res_valid=1, res_parity=0, res_id=0 one cycle after the last bit.
REQ-033 Contention: req=11 held from reset release, frame bits 1,0,0,0,0,0,0,0 for each requester -> requester 0 is served first (res_id=0, parity 1), then requester 1 (res_id=1, parity 1); grants alternate.
REQ-034 Stalls and backpressure: requester 1 alone, in_valid low on 3 interleaved cycles, bits all 1, res_ready held low for 4 cycles -> res_parity=0 (8 ones), and res_valid/res_parity/res_id stay stable until res_ready rises.
REQ-035 Abort: req[0] drops after 5 bits -> gnt=00 next cycle, no res_valid pulse; with req=11 pending, the next grant goes to requester 1.
REQ-036 Reset mid-operation: rst=1 for one cycle during ACCUM after 4 bits -> all outputs at reset values the next cycle; a new frame afterwards gives the correct parity with no residue from the discarded bits.
REQ-037 Non-granted noise: requester 1 toggles in_valid and in_bit while requester 0 is granted -> the result equals requester 0's data alone.

Source files
------------

// File: rtl/parity_sched_pkg.sv
// Shared types and constants for the two-requester
// serial parity scheduler.
package parity_sched_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/parity_acc.sv
// Running-parity flop: clear has priority over enable,
// enable folds d into the stored parity.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  logic r_q;

  // Clear or fold one data bit into the running parity.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= 1'b0;
    end else if (en) begin
      r_q <= r_q ^ d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/parity_sched.sv
// Round-robin two-requester arbiter that accumulates the
// parity of one granted serial frame at a time.
module parity_sched
  import parity_sched_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic [NREQ-1:0] in_valid,
  input  logic [NREQ-1:0] in_bit,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_parity,
  output logic            res_id
);

  state_t     r_state;
  logic       r_g;
  logic       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic       r_par;
  logic       r_id;

  state_t     w_state_nxt;
  logic       w_g_nxt;
  logic       w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic       w_par_nxt;
  logic       w_id_nxt;
  logic       w_clr;
  logic       w_en;
  logic       w_acc;
  logic       w_win;
  logic       w_vld;
  logic       w_bit;
  logic       w_keep;
  logic       w_last;

  // r_ptr names the favoured requester on a tie.
  assign w_win  = (req == 2'b11) ? r_ptr : req[1];
  assign w_vld  = in_valid[r_g];
  assign w_bit  = in_bit[r_g];
  assign w_keep = req[r_g];
  assign w_last = (r_cnt == CNT_W'(FRAME_LEN - 1));

  parity_acc u_acc (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_en),
    .d   (w_bit),
    .q   (w_acc)
  );

  // Next-state, arbitration and result-latch decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    w_id_nxt    = r_id;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_g_nxt     = w_win;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (!w_keep) begin
          w_ptr_nxt   = ~r_g;
          w_state_nxt = IDLE;
        end else if (w_vld) begin
          if (w_last) begin
            w_par_nxt   = w_acc ^ w_bit;
            w_id_nxt    = r_g;
            w_ptr_nxt   = ~r_g;
            w_state_nxt = RESULT;
          end else begin
            w_en      = 1'b1;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      RESULT: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_g     <= 1'b0;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_par   <= w_par_nxt;
      r_id    <= w_id_nxt;
    end
  end

  assign gnt        = (r_state == ACCUM) ?
                      (NREQ'(1) << r_g) : '0;
  assign res_valid  = (r_state == RESULT);
  assign res_parity = r_par;
  assign res_id     = r_id;

endmodule

// File: tb/tb_parity_sched.sv
// Self-checking bench for parity_sched: vector table,
// directed corner sequences and a randomized model run.
module tb_parity_sched;

  localparam int FL = 8;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] in_valid;
  logic [1:0] in_bit;
  logic       res_valid;
  logic       res_ready;
  logic       res_parity;
  logic       res_id;

  int checks;
  int failures;

  parity_sched #(.FRAME_LEN(FL), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_parity (res_parity),
    .res_id     (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: who owns the bus,
  // the bits collected so far, and any pending result.
  int   m_owner;
  bit   m_q[$];
  bit   m_hr;
  bit   m_par;
  bit   m_id;
  int   m_last;

  task automatic model_step();
    bit p;
    if (rst) begin
      m_owner = -1;
      m_q.delete();
      m_hr = 0; m_par = 0; m_id = 0;
      m_last = 1;
    end else if (m_hr) begin
      if (res_ready) m_hr = 0;
    end else if (m_owner < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) m_owner = 1 - m_last;
        else m_owner = req[1] ? 1 : 0;
        m_q.delete();
      end
    end else if (!req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (in_valid[m_owner]) begin
      m_q.push_back(in_bit[m_owner]);
      if (m_q.size() == FL) begin
        p = 0;
        foreach (m_q[i]) p ^= m_q[i];
        m_par   = p;
        m_id    = (m_owner == 1);
        m_hr    = 1;
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] rq,
                     input logic [1:0] vi,
                     input logic [1:0] bi,
                     input logic rd);
    rst = r; req = rq; in_valid = vi;
    in_bit = bi; res_ready = rd;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [1:0] eg;
    eg = (m_owner < 0) ? 2'b00 : (2'b01 << m_owner);
    chk({tag, "_gnt"}, 8'(gnt), 8'(eg));
    chk({tag, "_rv"}, 8'(res_valid), 8'(m_hr));
    if (m_hr) begin
      chk({tag, "_par"}, 8'(res_parity), 8'(m_par));
      chk({tag, "_id"}, 8'(res_id), 8'(m_id));
    end
  endtask

  typedef struct {
    logic       r;
    logic [1:0] rq;
    logic [1:0] vi;
    logic [1:0] bi;
    logic       rd;
    logic [1:0] eg;
    logic       erv;
    logic       epar;
    logic       eid;
  } vec_t;

  function automatic vec_t mk(
    logic r, logic [1:0] rq, logic [1:0] vi,
    logic [1:0] bi, logic rd, logic [1:0] eg,
    logic erv, logic epar, logic eid);
    vec_t v;
    v.r = r; v.rq = rq; v.vi = vi; v.bi = bi;
    v.rd = rd; v.eg = eg; v.erv = erv;
    v.epar = epar; v.eid = eid;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    logic [7:0] pat;
    logic [10:0] vp;
    logic [7:0] d0;
    logic       b;
    logic [1:0] ids;
    logic [1:0] pars;
    int         n;
    logic [1:0] hr;
    checks = 0;
    failures = 0;
    m_owner = -1; m_hr = 0; m_par = 0;
    m_id = 0; m_last = 1;
    rst = 1; req = 0; in_valid = 0;
    in_bit = 0; res_ready = 0;

    // Single frame 1,0,1,1,0,0,1,0 from requester 0.
    pat = 8'b01001101;
    tbl[0] = mk(1, 2'b00, 2'b00, 2'b00, 0,
                2'b00, 0, 0, 0);
    tbl[1] = mk(0, 2'b01, 2'b00, 2'b00, 0,
                2'b01, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      tbl[2+k] = mk(0, 2'b01, 2'b01, {1'b0, pat[k]}, 0,
                    (k < 7) ? 2'b01 : 2'b00,
                    (k == 7), 0, 0);
    tbl[10] = mk(0, 2'b00, 2'b00, 2'b00, 0,
                 2'b00, 1, 0, 0);
    tbl[11] = mk(0, 2'b00, 2'b00, 2'b00, 1,
                 2'b00, 0, 0, 0);
    tbl[12] = mk(0, 2'b01, 2'b00, 2'b00, 0,
                 2'b01, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].r, tbl[i].rq, tbl[i].vi,
          tbl[i].bi, tbl[i].rd);
      chk($sformatf("vec%0d_gnt", i), 8'(gnt), 8'(tbl[i].eg));
      chk($sformatf("vec%0d_rv", i), 8'(res_valid), 8'(tbl[i].erv));
      chk($sformatf("vec%0d_par", i), 8'(res_parity), 8'(tbl[i].epar));
      chk($sformatf("vec%0d_id", i), 8'(res_id), 8'(tbl[i].eid));
    end

    // Contention: both request from reset release.
    cyc(1, 2'b00, 2'b00, 2'b00, 1);
    n = 0; ids = 0; pars = 0;
    for (int c = 0; c < 30; c++) begin
      b = (m_owner >= 0 && m_q.size() == 0);
      cyc(0, 2'b11, 2'b11, {b, b}, 1);
      chk_model("cont");
      if (res_valid && n < 2) begin
        ids[n]  = res_id;
        pars[n] = res_parity;
        n++;
      end
    end
    chk("cont_nres", 8'(n), 8'd2);
    chk("cont_ids", 8'(ids), 8'b10);
    chk("cont_pars", 8'(pars), 8'b11);

    // Stalls plus backpressure, requester 1 all ones.
    cyc(1, 2'b00, 2'b00, 2'b00, 0);
    cyc(0, 2'b10, 2'b00, 2'b00, 0);
    chk("stall_gnt", 8'(gnt), 8'b10);
    vp = 11'b11101101101;
    for (int k = 0; k < 11; k++) begin
      cyc(0, 2'b10, {vp[k], 1'b1}, 2'b11, 0);
      chk_model("stall");
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 2'b01, 2'b00, 2'b00, 0);
      chk("bp_rv", 8'(res_valid), 8'd1);
      chk("bp_par", 8'(res_parity), 8'd0);
      chk("bp_id", 8'(res_id), 8'd1);
      chk("bp_gnt", 8'(gnt), 8'd0);
    end
    cyc(0, 2'b00, 2'b00, 2'b00, 1);
    chk("bp_release", 8'(res_valid), 8'd0);

    // Abort after five bits, requester 1 pending.
    cyc(1, 2'b00, 2'b00, 2'b00, 1);
    cyc(0, 2'b11, 2'b00, 2'b00, 1);
    chk("abort_g0", 8'(gnt), 8'b01);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 2'b11, 2'b01, 2'b01, 1);
      chk_model("abort");
    end
    cyc(0, 2'b10, 2'b01, 2'b01, 1);
    chk("abort_gnt", 8'(gnt), 8'b00);
    chk("abort_rv", 8'(res_valid), 8'd0);
    cyc(0, 2'b11, 2'b00, 2'b00, 1);
    chk("abort_next", 8'(gnt), 8'b10);

    // Reset mid-frame, then a clean frame.
    cyc(1, 2'b00, 2'b00, 2'b00, 1);
    cyc(0, 2'b01, 2'b00, 2'b00, 1);
    for (int k = 0; k < 4; k++)
      cyc(0, 2'b01, 2'b01, 2'b01, 1);
    cyc(1, 2'b01, 2'b01, 2'b01, 1);
    chk("rst_gnt", 8'(gnt), 8'd0);
    chk("rst_rv", 8'(res_valid), 8'd0);
    chk("rst_par", 8'(res_parity), 8'd0);
    chk("rst_id", 8'(res_id), 8'd0);
    cyc(0, 2'b01, 2'b00, 2'b00, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 2'b01, 2'b01, {1'b0, k == 0}, 0);
      chk_model("rstf");
    end
    chk("rstf_rv", 8'(res_valid), 8'd1);
    chk("rstf_par", 8'(res_parity), 8'd1);

    // Requester 1 noise while requester 0 is granted.
    cyc(1, 2'b00, 2'b00, 2'b00, 1);
    cyc(0, 2'b01, 2'b00, 2'b00, 1);
    d0 = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 2'b01, {1'($urandom), 1'b1},
          {1'($urandom), d0[k]}, 0);
      chk_model("noise");
    end
    chk("noise_rv", 8'(res_valid), 8'd1);
    chk("noise_par", 8'(res_parity), 8'(^d0));
    chk("noise_id", 8'(res_id), 8'd0);

    // Randomized run against the reference model.
    cyc(1, 2'b00, 2'b00, 2'b00, 0);
    hr = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) hr = 2'($urandom);
      cyc($urandom_range(0, 199) == 0, hr,
          2'($urandom), 2'($urandom),
          1'($urandom));
      chk_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
